// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush generator for the 5-stage pipeline: fixed-priority hazard resolution
// with a small wait FSM, watchdog and saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int NREG   = 4,
    parameter int WDOG_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_load_use,
    input  logic             ex_br_taken,
    input  logic             ex_div_start,
    input  logic             div_done,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             wb_excp,
    output logic             pc_stall,
    output logic [1:0]       pc_redirect,
    output logic [NREG-1:0]  stall,
    output logic [NREG-1:0]  flush,
    output logic             wdog_err,
    output logic [CNT_W-1:0] stall_cnt
);

    // state    | meaning
    // RUN      | no multi-cycle wait outstanding
    // MEM_WAIT | data memory access pending, EX and earlier held
    // DIV_WAIT | divider busy, ID and earlier held
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_DIV_WAIT = 2'd2;

    logic [1:0]        state;
    logic              div_pend;
    logic [WDOG_W-1:0] wdog;
    logic [WDOG_W-1:0] wdog_inc;
    logic              wdog_to;
    logic              mem_act;
    logic              div_act;

    assign wdog_inc = wdog + 1'b1;
    assign wdog_to  = &wdog_inc;

    always_comb begin
        pc_stall    = 1'b0;
        pc_redirect = 2'b00;
        stall       = '0;
        flush       = '0;
        mem_act     = (state == ST_RUN && mem_req && !mem_ack) ||
                      (state == ST_MEM_WAIT && !mem_ack);
        div_act     = (state == ST_DIV_WAIT) && !div_done;
        if (rst) begin
            if (wb_excp) begin
                flush       = NREG'(4'b1111);
                pc_redirect = 2'b10;
            end else if (mem_act) begin
                pc_stall = 1'b1;
                stall    = NREG'(4'b0111);
                flush    = NREG'(4'b1000);
            end else if (div_act) begin
                pc_stall = 1'b1;
                stall    = NREG'(4'b0011);
                flush    = NREG'(4'b0100);
            end else if (ex_br_taken) begin
                // the dependent ID instr is killed, so load-use is moot
                flush       = NREG'(4'b0011);
                pc_redirect = 2'b01;
            end else if (id_load_use) begin
                pc_stall = 1'b1;
                stall    = NREG'(4'b0001);
                flush    = NREG'(4'b0010);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            div_pend  <= 1'b0;
            wdog      <= '0;
            wdog_err  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (pc_stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;

            if (wb_excp) begin
                state    <= ST_RUN;
                div_pend <= 1'b0;
                wdog     <= '0;
            end else begin
                case (state)
                    ST_RUN: begin
                        wdog <= '0;
                        if (mem_req && !mem_ack) begin
                            state    <= ST_MEM_WAIT;
                            div_pend <= ex_div_start;
                        end else if (ex_div_start) begin
                            state <= ST_DIV_WAIT;
                        end
                    end
                    ST_MEM_WAIT: begin
                        // watchdog restarts so a deferred divide gets its own budget
                        if (mem_ack) begin
                            state    <= div_pend ? ST_DIV_WAIT : ST_RUN;
                            div_pend <= 1'b0;
                            wdog     <= '0;
                        end else if (wdog_to) begin
                            state    <= ST_RUN;
                            div_pend <= 1'b0;
                            wdog     <= '0;
                            wdog_err <= 1'b1;
                        end else begin
                            wdog <= wdog_inc;
                        end
                    end
                    ST_DIV_WAIT: begin
                        if (div_done) begin
                            state <= ST_RUN;
                            wdog  <= '0;
                        end else if (wdog_to) begin
                            state    <= ST_RUN;
                            wdog     <= '0;
                            wdog_err <= 1'b1;
                        end else begin
                            wdog <= wdog_inc;
                        end
                    end
                    default: begin
                        state    <= ST_RUN;
                        div_pend <= 1'b0;
                        wdog     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; small watchdog and counter widths
// so timeout and saturation are reachable in a few cycles.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_load_use, ex_br_taken, ex_div_start, div_done;
    logic       mem_req, mem_ack, wb_excp;
    logic       pc_stall;
    logic [1:0] pc_redirect;
    logic [3:0] stall, flush;
    logic       wdog_err;
    logic [3:0] stall_cnt;
    logic [10:0] obs;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.NREG(4), .WDOG_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_load_use(id_load_use), .ex_br_taken(ex_br_taken),
        .ex_div_start(ex_div_start), .div_done(div_done),
        .mem_req(mem_req), .mem_ack(mem_ack), .wb_excp(wb_excp),
        .pc_stall(pc_stall), .pc_redirect(pc_redirect),
        .stall(stall), .flush(flush),
        .wdog_err(wdog_err), .stall_cnt(stall_cnt)
    );

    // {pc_stall, pc_redirect, stall, flush}
    assign obs = {pc_stall, pc_redirect, stall, flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_load_use = 0; ex_br_taken = 0; ex_div_start = 0; div_done = 0;
        mem_req = 0; mem_ack = 0; wb_excp = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; wb_excp = 1; mem_req = 1; id_load_use = 1;
        #1;
        checks++; if (obs !== 11'b0) begin errors++; $display("FAIL reset_forced_zero: got %b expected %b", obs, 11'b0); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); end
        checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL reset_wdog: got %b expected 0", wdog_err); end
        @(negedge clk);
        clear_inputs(); rst = 1'b1;
        #1;
        checks++; if (obs !== 11'b0) begin errors++; $display("FAIL reset_release_idle: got %b expected %b", obs, 11'b0); end
    endtask

    task automatic test_load_use();
        apply_reset();
        @(negedge clk); id_load_use = 1; #1;
        checks++; if (obs !== 11'b1_00_0001_0010) begin errors++; $display("FAIL load_use: got %b expected %b", obs, 11'b1_00_0001_0010); end
        @(negedge clk); id_load_use = 0; #1;
        checks++; if (obs !== 11'b0) begin errors++; $display("FAIL load_use_one_cycle: got %b expected %b", obs, 11'b0); end
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_branch_over_load_use();
        apply_reset();
        @(negedge clk); id_load_use = 1; ex_br_taken = 1; #1;
        checks++; if (obs !== 11'b0_01_0000_0011) begin errors++; $display("FAIL br_over_lu: got %b expected %b", obs, 11'b0_01_0000_0011); end
        @(negedge clk); clear_inputs(); #1;
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL br_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        @(negedge clk); mem_req = 1; #1;
        checks++; if (obs !== 11'b1_00_0111_1000) begin errors++; $display("FAIL mem_first: got %b expected %b", obs, 11'b1_00_0111_1000); end
        @(negedge clk); ex_br_taken = 1; #1;
        checks++; if (obs !== 11'b1_00_0111_1000) begin errors++; $display("FAIL mem_br_ignored: got %b expected %b", obs, 11'b1_00_0111_1000); end
        @(negedge clk); #1;
        checks++; if (obs !== 11'b1_00_0111_1000) begin errors++; $display("FAIL mem_third: got %b expected %b", obs, 11'b1_00_0111_1000); end
        @(negedge clk); mem_ack = 1; #1;
        checks++; if (obs !== 11'b0_01_0000_0011) begin errors++; $display("FAIL mem_ack_run_out: got %b expected %b", obs, 11'b0_01_0000_0011); end
        @(negedge clk); clear_inputs(); #1;
        checks++; if (obs !== 11'b0) begin errors++; $display("FAIL mem_back_run: got %b expected %b", obs, 11'b0); end
        checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL mem_cnt: got %0d expected 3", stall_cnt); end
    endtask

    task automatic test_div_excp();
        apply_reset();
        @(negedge clk); ex_div_start = 1; #1;
        checks++; if (obs !== 11'b0) begin errors++; $display("FAIL div_start_cycle: got %b expected %b", obs, 11'b0); end
        @(negedge clk); ex_div_start = 0; #1;
        checks++; if (obs !== 11'b1_00_0011_0100) begin errors++; $display("FAIL div_wait: got %b expected %b", obs, 11'b1_00_0011_0100); end
        @(negedge clk); wb_excp = 1; #1;
        checks++; if (obs !== 11'b0_10_0000_1111) begin errors++; $display("FAIL excp: got %b expected %b", obs, 11'b0_10_0000_1111); end
        @(negedge clk); wb_excp = 0; #1;
        checks++; if (obs !== 11'b0) begin errors++; $display("FAIL excp_to_run: got %b expected %b", obs, 11'b0); end
        @(negedge clk); div_done = 1; #1;
        checks++; if (obs !== 11'b0) begin errors++; $display("FAIL late_div_done: got %b expected %b", obs, 11'b0); end
        @(negedge clk); div_done = 0; #1;
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL div_excp_cnt: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_mem_div_defer();
        apply_reset();
        @(negedge clk); mem_req = 1; ex_div_start = 1; #1;
        checks++; if (obs !== 11'b1_00_0111_1000) begin errors++; $display("FAIL defer_mem_wins: got %b expected %b", obs, 11'b1_00_0111_1000); end
        @(negedge clk); ex_div_start = 0; mem_ack = 1; #1;
        checks++; if (obs !== 11'b0) begin errors++; $display("FAIL defer_ack: got %b expected %b", obs, 11'b0); end
        @(negedge clk); mem_req = 0; mem_ack = 0; #1;
        checks++; if (obs !== 11'b1_00_0011_0100) begin errors++; $display("FAIL defer_div_wait: got %b expected %b", obs, 11'b1_00_0011_0100); end
        @(negedge clk); div_done = 1; id_load_use = 1; #1;
        checks++; if (obs !== 11'b1_00_0001_0010) begin errors++; $display("FAIL div_done_run_out: got %b expected %b", obs, 11'b1_00_0001_0010); end
        @(negedge clk); clear_inputs(); #1;
        checks++; if (obs !== 11'b0) begin errors++; $display("FAIL defer_back_run: got %b expected %b", obs, 11'b0); end
        checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL defer_cnt: got %0d expected 3", stall_cnt); end
    endtask

    task automatic test_watchdog();
        apply_reset();
        @(negedge clk); mem_req = 1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (pc_stall !== 1'b1 || wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_wait_%0d: got stall=%b err=%b expected stall=1 err=0", i, pc_stall, wdog_err); end
        end
        @(negedge clk); mem_req = 0; #1;
        checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_fire: got %b expected 1", wdog_err); end
        checks++; if (obs !== 11'b0) begin errors++; $display("FAIL wdog_forced_run: got %b expected %b", obs, 11'b0); end
        checks++; if (stall_cnt !== 4'd8) begin errors++; $display("FAIL wdog_cnt: got %0d expected 8", stall_cnt); end
        @(negedge clk); #1;
        checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_sticky: got %b expected 1", wdog_err); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_rst_clear: got %b expected 0", wdog_err); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); id_load_use = 1;
        end
        @(negedge clk); id_load_use = 0; #1;
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL cnt_saturate: got %0d expected 15", stall_cnt); end
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch_over_load_use();
        test_mem_wait();
        test_div_excp();
        test_mem_div_defer();
        test_watchdog();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
